// File: rtl/sub_serial_pkg.sv
// Shared definitions for the bit-serial borrow subtractor: FSM state
// encoding and the bit-counter width derivation.
package sub_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter only has to reach N-1, so $clog2(N) bits suffice for N >= 2.
    function automatic int cw_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/sub_borrow_serial.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^N), bout = (a < b),
// processed LSB first, one bit per clock, with a start/ready/done_tick handshake.
module sub_borrow_serial
    import sub_serial_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done_tick,
    output logic [N-1:0] diff,
    output logic         bout
);

    localparam int CW = cw_of(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          br_q, br_d;
    logic          bout_q, bout_d;
    logic [CW-1:0] count_q, count_d;

    logic          fs_d;
    logic          fs_bout;

    full_sub u_full_sub (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        diff_d    = diff_q;
        br_d      = br_q;
        bout_d    = bout_q;
        count_d   = count_q;
        ready     = 1'b0;
        done_tick = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = 1'b0;
                    count_d = '0;
                    diff_d  = '0;
                    state_d = ST_OP;
                end
            end
            ST_OP: begin
                // Result bits enter at the MSB so that after N shifts bit 0 is the LSB.
                diff_d  = {fs_d, diff_q[N-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                br_d    = fs_bout;
                count_d = count_q + CW'(1);
                if (count_q == LAST_BIT) begin
                    bout_d  = fs_bout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_tick = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Results are cleared on reset too, so an aborted operation leaves zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            count_q <= count_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_sub_borrow_serial.sv
// Directed, table-driven bench for sub_borrow_serial at N=4.
module tb_sub_borrow_serial;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ready;
    logic         done_tick;
    logic [N-1:0] diff;
    logic         bout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    sub_borrow_serial #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .done_tick (done_tick),
        .diff      (diff),
        .bout      (bout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge while idle; returns cycles from start to done_tick.
    task automatic run_op(input logic [3:0] aa, input logic [3:0] bb, output int k);
        a     = aa;
        b     = bb;
        start = 1'b1;
        k     = 0;
        do begin
            @(negedge clk);
            k++;
            start = 1'b0;
        end while (!done_tick && k < 20);
    endtask

    initial begin
        int   k;
        int   ndone;
        logic [3:0] cap_d;
        logic       cap_b;
        logic [4:0] ref5;

        vecs[0] = '{4'h9, 4'h3, 4'h6, 1'b0};
        vecs[1] = '{4'h3, 4'h9, 4'hA, 1'b1};
        vecs[2] = '{4'h0, 4'h1, 4'hF, 1'b1};
        vecs[3] = '{4'hF, 4'hF, 4'h0, 1'b0};
        vecs[4] = '{4'h8, 4'h2, 4'h6, 1'b0};
        vecs[5] = '{4'h0, 4'h0, 4'h0, 1'b0};
        vecs[6] = '{4'hF, 4'h0, 4'hF, 1'b0};
        vecs[7] = '{4'h0, 4'hF, 4'h1, 1'b1};
        vecs[8] = '{4'h7, 4'h8, 4'hF, 1'b1};
        vecs[9] = '{4'h5, 4'h5, 4'h0, 1'b0};

        reset = 1'b1;
        start = 1'b1;
        a     = 4'hC;
        b     = 4'h3;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done_tick), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        chk("reset_bout", 32'(bout), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, k);
            chk($sformatf("vec%0d_latency", i), 32'(k), 32'd5);
            chk($sformatf("vec%0d_diff", i), 32'(diff), 32'(vecs[i].d));
            chk($sformatf("vec%0d_bout", i), 32'(bout), 32'(vecs[i].bo));
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 32'(done_tick), 32'd0);
            chk($sformatf("vec%0d_ready_after", i), 32'(ready), 32'd1);
            chk($sformatf("vec%0d_diff_held", i), 32'(diff), 32'(vecs[i].d));
        end

        // Second start during OP must be ignored, and input changes after capture too.
        a     = 4'h8;
        b     = 4'h2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("ignore_ready_low", 32'(ready), 32'd0);
        a     = 4'h1;
        b     = 4'h1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 4'h7;
        b     = 4'hC;
        ndone = 0;
        cap_d = 4'h0;
        cap_b = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (done_tick) begin
                ndone++;
                cap_d = diff;
                cap_b = bout;
            end
        end
        chk("ignore_done_count", 32'(ndone), 32'd1);
        chk("ignore_diff", 32'(cap_d), 32'h6);
        chk("ignore_bout", 32'(cap_b), 32'd0);

        // Reset two cycles into OP aborts the operation.
        run_op(4'h0, 4'h1, k);
        @(negedge clk);
        a     = 4'h9;
        b     = 4'h3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done_tick), 32'd0);
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done_tick) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        // Exhaustive sweep with start held high.
        a     = 4'h0;
        b     = 4'h0;
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ref5 = {1'b0, 4'(i >> 4)} - {1'b0, 4'(i & 15)};
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!done_tick && k < 20);
            chk($sformatf("sweep_a%0d_b%0d", i >> 4, i & 15), 32'({bout, diff}), 32'(ref5));
            chk($sformatf("sweep_spacing%0d", i), 32'(k), (i == 0) ? 32'd5 : 32'd6);
            if (i < 255) begin
                a = 4'((i + 1) >> 4);
                b = 4'((i + 1) & 15);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("sweep_ready_end", 32'(ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
